aes_round_sequencer: RTL and testbench

- Iterative AES encryption controller that time-shares one external combinational round datapath over all NR rounds of a 128-bit block.
- Sequences the round index, supplies round keys from an external key store and applies the initial AddRoundKey internally.
- Flags the final round so the datapath omits MixColumns, and hands the result out on a valid/ready interface.
- Sits between the block-level stream interface and the shared round unit plus key-store RAM.

---
 rtl/aes_round_sequencer_if.sv | 41 ++++
 rtl/aes_round_sequencer.sv | 102 ++++++++++
 tb/tb_aes_round_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer_if
// Brief    : Stream, key-store and round-datapath bundle of the AES sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_round_sequencer_if #(
    parameter int W     = 128,
    parameter int IW    = 4,
    parameter int CNT_W = 32
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [IW-1:0]    rk_idx;
    logic [W-1:0]     rk_data;
    logic [W-1:0]     rnd_state;
    logic [W-1:0]     rnd_key;
    logic             rnd_last;
    logic [W-1:0]     rnd_result;
    logic             busy;
    logic [CNT_W-1:0] blk_count;

    // master is the sequencer; slave is the surrounding stream/key/datapath logic
    modport master (
        input  clear, in_valid, in_data, out_ready, rk_data, rnd_result,
        output in_ready, out_valid, out_data, rk_idx, rnd_state, rnd_key,
        output rnd_last, busy, blk_count
    );

    modport slave (
        output clear, in_valid, in_data, out_ready, rk_data, rnd_result,
        input  in_ready, out_valid, out_data, rk_idx, rnd_state, rnd_key,
        input  rnd_last, busy, blk_count
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Brief    : Iterative AES controller time-sharing one external round datapath.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
    parameter int NR    = 10,
    parameter int W     = 128,
    parameter int CNT_W = 32,
    parameter int IW    = $clog2(NR + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    aes_round_sequencer_if.master bus
);
    localparam logic [IW-1:0] c_last_rnd = IW'(NR);
    localparam logic [IW-1:0] c_one      = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_rnd;
    logic [W-1:0]     r_block;
    logic [CNT_W-1:0] r_blk_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_rnd_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rnd       <= '0;
            r_block     <= '0;
            r_blk_count <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rnd_last  <= 1'b0;
        end else if (bus.clear) begin
            // abort wins over everything, including a coincident output handshake
            r_state     <= S_IDLE;
            r_rnd       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rnd_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_block    <= bus.in_data ^ bus.rk_data;
                        r_rnd      <= c_one;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_rnd_last <= (c_last_rnd == c_one);
                        r_state    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_block <= bus.rnd_result;
                    if (r_rnd == c_last_rnd) begin
                        r_rnd_last  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_rnd      <= r_rnd + c_one;
                        r_rnd_last <= ((r_rnd + c_one) == c_last_rnd);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_blk_count <= r_blk_count + CNT_W'(1);
                        r_rnd       <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_block;
    assign bus.rk_idx    = r_rnd;
    assign bus.rnd_state = r_block;
    assign bus.rnd_key   = bus.rk_data;
    assign bus.rnd_last  = r_rnd_last;
    assign bus.busy      = r_busy;
    assign bus.blk_count = r_blk_count;
endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_sequencer
// Brief    : Bench with an AES-128 reference round unit, key store and model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;
    localparam int NR = 10;
    localparam logic [127:0] c_key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    logic [127:0] rk_tab [16];
    logic [127:0] pts [3];
    logic [127:0] outs [3];
    int           acc [3];
    int           n_acc, n_out, lat;
    logic [127:0] d0;
    logic [31:0]  cnt0;
    logic         seen;

    aes_round_sequencer_if #(.W(128), .IW(4), .CNT_W(32)) bus();

    aes_round_sequencer #(.NR(NR), .W(128), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            v = gmul(v, v);
            if (i != 0) v = gmul(v, a);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ key;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= NR; r++) s = aes_round(s, rk_tab[r], r == NR);
        return s;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // external key store and round datapath
    assign bus.rk_data = rk_tab[bus.rk_idx];
    always_comb bus.rnd_result = aes_round(bus.rnd_state, bus.rnd_key, bus.rnd_last);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: m_age counts edges since the accepting edge (-1 when idle)
    int           m_age = -1;
    logic         m_ready = 1'b0;
    logic [127:0] m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age   <= -1;
            m_ready <= 1'b0;
        end else if (bus.clear) begin
            m_age   <= -1;
            m_ready <= 1'b1;
        end else if (m_age < 0) begin
            if (bus.in_valid && m_ready) begin
                m_age   <= 1;
                m_ready <= 1'b0;
                m_exp   <= aes_encrypt(bus.in_data);
            end else begin
                m_ready <= 1'b1;
            end
        end else if (m_age > NR) begin
            if (bus.out_ready) begin
                m_age   <= -1;
                m_ready <= 1'b1;
            end
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_in_ready", 128'(bus.in_ready), 128'(m_ready));
            check("m_out_valid", 128'(bus.out_valid), 128'(m_age > NR));
            check("m_busy", 128'(bus.busy), 128'(m_age >= 1));
            check("m_rnd_last", 128'(bus.rnd_last), 128'(m_age == NR));
            if (m_age <= NR) check("m_rk_idx", 128'(bus.rk_idx), 128'(m_age < 0 ? 0 : m_age));
            if (m_age > NR) check("m_out_data", bus.out_data, m_exp);
        end
    end

    task automatic accept_block(input logic [127:0] pt);
        @(negedge clk);
        bus.in_data  = pt;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !bus.in_ready; i++) @(negedge clk);
        check("accept_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check("wait_out_valid", 128'(bus.out_valid), 128'(1));
    endtask

    task automatic wait_rk_idx(input int k);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rk_idx == 4'(k)) break;
        end
        check("wait_rk_idx", 128'(bus.rk_idx), 128'(k));
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        expand_key(c_key);
        pts[0] = c_pt;
        pts[1] = 128'h0123456789abcdeffedcba9876543210;
        pts[2] = 128'hffffffffffffffffffffffffffffffff;

        // model anchors from FIPS-197
        check("pin_sbox53", 128'(sbox(8'h53)), 128'(8'hed));
        check("pin_rk1", rk_tab[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("pin_rk10", rk_tab[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("pin_encrypt", aes_encrypt(c_pt), c_ct);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_blk_count", 128'(bus.blk_count), 128'(0));
        check("rst_rk_idx", 128'(bus.rk_idx), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));

        // FIPS-197 C.1 with sequencing
        bus.out_ready = 1'b1;
        accept_block(c_pt);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k - 1;
                break;
            end
            check("seq_rk_idx", 128'(bus.rk_idx), 128'(k));
            check("seq_rnd_last", 128'(bus.rnd_last), 128'(k == 10));
            check("seq_in_ready", 128'(bus.in_ready), 128'(0));
        end
        check("latency", 128'(lat), 128'(10));
        check("c1_out_data", bus.out_data, c_ct);
        @(negedge clk);
        check("c1_blk_count", 128'(bus.blk_count), 128'(1));

        // backpressure
        bus.out_ready = 1'b0;
        accept_block(pts[1]);
        wait_out_valid();
        d0   = bus.out_data;
        cnt0 = bus.blk_count;
        check("bp_data", d0, aes_encrypt(pts[1]));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            @(negedge clk);
            check("bp_stable", bus.out_data, d0);
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
            check("bp_count", 128'(bus.blk_count), 128'(cnt0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_count_inc", 128'(bus.blk_count), 128'(2));

        // back-to-back
        sync_reset();
        bus.out_ready = 1'b1;
        bus.in_data   = pts[0];
        bus.in_valid  = 1'b1;
        n_acc = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 100 && n_out < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus.out_valid) begin
                outs[n_out] = bus.out_data;
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (n_acc < 3) bus.in_data = pts[n_acc];
            else bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        check("b2b_outputs", 128'(n_out), 128'(3));
        check("b2b_spacing1", 128'(acc[1] - acc[0]), 128'(12));
        check("b2b_spacing2", 128'(acc[2] - acc[1]), 128'(12));
        check("b2b_ct0", outs[0], c_ct);
        check("b2b_ct1", outs[1], aes_encrypt(pts[1]));
        check("b2b_ct2", outs[2], aes_encrypt(pts[2]));
        @(negedge clk);
        check("b2b_blk_count", 128'(bus.blk_count), 128'(3));

        // abort at round 5
        bus.out_ready = 1'b0;
        accept_block(pts[2]);
        wait_rk_idx(5);
        bus.clear = 1'b1;
        @(posedge clk);
        #1 bus.clear = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 128'(bus.in_ready), 128'(1));
        check("abort_busy", 128'(bus.busy), 128'(0));
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_valid", 128'(seen), 128'(0));
        bus.out_ready = 1'b1;
        accept_block(c_pt);
        wait_out_valid();
        check("abort_then_c1", bus.out_data, c_ct);
        @(negedge clk);
        check("abort_blk_count", 128'(bus.blk_count), 128'(4));

        // clear coincident with the output handshake
        bus.out_ready = 1'b0;
        accept_block(pts[1]);
        wait_out_valid();
        bus.clear     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("clr_hs_count", 128'(bus.blk_count), 128'(4));
        check("clr_hs_valid", 128'(bus.out_valid), 128'(0));

        // asynchronous reset in round 7
        accept_block(pts[0]);
        wait_rk_idx(7);
        #1 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 128'(bus.in_ready), 128'(0));
        check("arst_busy", 128'(bus.busy), 128'(0));
        check("arst_rk_idx", 128'(bus.rk_idx), 128'(0));
        check("arst_out_data", bus.out_data, 128'h0);
        check("arst_blk_count", 128'(bus.blk_count), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // completed-block counter wrap
        #1 force dut.r_blk_count = 32'hffff_ffff;
        #1 release dut.r_blk_count;
        #1 check("wrap_preload", 128'(bus.blk_count), 128'(32'hffff_ffff));
        bus.out_ready = 1'b1;
        accept_block(pts[2]);
        wait_out_valid();
        @(negedge clk);
        check("wrap_blk_count", 128'(bus.blk_count), 128'(0));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
